// File: rtl/sqrt_sched_pkg.sv
// Shared definitions for the sqrt scheduler: FSM state encoding, default widths
// and a width helper for index/counter registers.
package sqrt_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int DEF_DW = 32;
  localparam int DEF_QW = 16;

  // Bits needed to hold values 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sqrt_scheduler_if.sv
// Requester and sqrt-core signals of the scheduler. slave = scheduler view,
// master = environment view (requesters plus the shared core).
interface sqrt_scheduler_if
  import sqrt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DEF_DW,
  parameter int QW   = DEF_QW
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_din;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [QW-1:0]      resp_dout;
  logic               resp_err;
  logic               sq_clear;
  logic               sq_enable;
  logic [DW-1:0]      sq_din;
  logic [QW-1:0]      sq_dout;
  logic               sq_valid;

  modport slave (
    input  req_valid, req_din, sq_dout, sq_valid,
    output req_ready, resp_valid, resp_dout, resp_err, sq_clear, sq_enable, sq_din
  );

  modport master (
    output req_valid, req_din, sq_dout, sq_valid,
    input  req_ready, resp_valid, resp_dout, resp_err, sq_clear, sq_enable, sq_din
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// The pointer register is owned by the instantiating module.
module rr_arbiter
  import sqrt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  int j;

  // Scan from farthest to nearest so the nearest request wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j[IW-1:0];
        any      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sqrt_scheduler.sv
// Shares one iterative sqrt core among NREQ requesters, one job in flight.
// Optional per-job watchdog enabled by defining SQRT_TIMEOUT_EN.
module sqrt_scheduler
  import sqrt_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = DEF_DW,
  parameter int QW      = DEF_QW,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  sqrt_scheduler_if.slave  bus,
  output logic             busy
);
  localparam int IW = clog2(NREQ);

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, owner_reg, grant_idx, ptr_next;
  logic [DW-1:0]   din_reg;
  logic [QW-1:0]   dout_reg;
  logic [NREQ-1:0] grant;
  logic            grant_any, accept, expired, err_flag;
  logic [1:0]      rst_sync_reg;
  logic            rst_n_int;
  logic [DW-1:0]   din_arr [NREQ];

  // Assertion is immediate, release is aligned to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_reg <= '0;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n_int = rst_sync_reg[1];

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign din_arr[gi]        = bus.req_din[gi*DW +: DW];
    assign bus.resp_valid[gi] = (state_reg == ST_RESP) && (owner_reg == IW'(gi));
  end

  assign accept        = (state_reg == ST_IDLE) && grant_any;
  assign bus.req_ready = (accept && rst_n_int) ? grant : '0;
  assign ptr_next      = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
  assign bus.sq_din    = din_reg;
  assign bus.resp_dout = dout_reg;

`ifdef SQRT_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_reg;
  logic          err_reg;

  assign expired      = (cnt_reg == CW'(TIMEOUT - 1));
  assign err_flag     = err_reg;
  assign bus.resp_err = err_reg;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == ST_LAUNCH)    cnt_reg <= '0;
      else if (state_reg == ST_WAIT) cnt_reg <= cnt_reg + 1'b1;
      if (state_reg == ST_WAIT && state_next == ST_RESP) err_reg <= !bus.sq_valid;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign expired      = 1'b0;
  assign err_flag     = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      din_reg   <= '0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        din_reg   <= din_arr[grant_idx];
        owner_reg <= grant_idx;
        ptr_reg   <= ptr_next;
      end
      // A real result wins over a watchdog expiry in the same cycle.
      if (state_reg == ST_WAIT) begin
        if (bus.sq_valid)  dout_reg <= bus.sq_dout;
        else if (expired)  dout_reg <= '0;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    busy          = 1'b1;
    bus.sq_clear  = 1'b0;
    bus.sq_enable = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (grant_any) state_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        bus.sq_clear = 1'b1;
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        bus.sq_enable = 1'b1;
        if (bus.sq_valid || expired) state_next = ST_RESP;
      end
      ST_RESP: begin
        bus.sq_clear = err_flag;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end
endmodule
